// File: rtl/prm_edge_scan.sv
// prm_edge_scan: sweeps an edge-code range into the obstacle checker and packs its masks into 32-bit words.
// Optional PRM_SCAN_CHK_PIPE_EN: checker treated as registered, masks pair with the previous cycle's code.
`default_nettype none

module prm_edge_scan #(
  parameter int CODE_W = 15,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CODE_W-1:0] first_code_i,
  input  logic [CODE_W-1:0] last_code_i,
  output logic [CODE_W-1:0] chk_code_o,
  input  logic              chk_mask_i,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [WORD_W-1:0] word_data_o,
  output logic [CODE_W-1:0] word_base_o,
  output logic [CNT_W-1:0]  blocked_cnt_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int IDX_W = $clog2(WORD_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            r_state;
  logic [CODE_W-1:0] r_cur;
  logic [CODE_W-1:0] r_last;
  logic [CODE_W-1:0] r_base;
  logic [WORD_W-1:0] r_pack;
  logic              r_valid;
  logic [WORD_W-1:0] r_data;
  logic [CODE_W-1:0] r_wbase;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;

  logic              w_samp_v;
  logic [CODE_W-1:0] w_scode;
  logic [CODE_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [WORD_W-1:0] w_bit;
  logic [WORD_W-1:0] w_pack_nxt;
  logic              w_final;
  logic              w_cmpl;
  logic              w_out_free;
  logic              w_cnt_inc;
  logic              w_adv;
  logic              w_hold_go;

`ifdef PRM_SCAN_CHK_PIPE_EN
  // Delay stage: the code whose mask arrives on chk_mask_i this cycle.
  logic              r_dv;
  logic [CODE_W-1:0] r_dcode;
  logic              r_issued_all;

  assign w_samp_v = (r_state == S_SCAN) && r_dv;
  assign w_scode  = r_dcode;
`else
  assign w_samp_v = (r_state == S_SCAN);
  assign w_scode  = r_cur;
`endif

  assign w_off      = w_scode - r_base;
  assign w_idx      = w_off[IDX_W-1:0];
  assign w_bit      = {{(WORD_W-1){1'b0}}, chk_mask_i} << w_idx;
  assign w_pack_nxt = r_pack | w_bit;
  assign w_final    = (w_scode == r_last);
  assign w_cmpl     = w_samp_v && (w_final || (w_off == CODE_W'(WORD_W-1)));
  assign w_out_free = !r_valid || word_ready_i;
  assign w_cnt_inc  = w_samp_v && chk_mask_i && (r_cnt != {CNT_W{1'b1}});
  assign w_adv      = (r_state == S_SCAN) && !(w_cmpl && (w_final || !w_out_free));
  assign w_hold_go  = (r_state == S_HOLD) && w_out_free && !w_final;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_last  <= '0;
      r_base  <= '0;
      r_pack  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_wbase <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
`ifdef PRM_SCAN_CHK_PIPE_EN
      r_dv         <= 1'b0;
      r_dcode      <= '0;
      r_issued_all <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_valid && word_ready_i) r_valid <= 1'b0;
      if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;

`ifdef PRM_SCAN_CHK_PIPE_EN
      if (w_adv) begin
        if (!r_issued_all) begin
          r_dv    <= 1'b1;
          r_dcode <= r_cur;
          if (r_cur == r_last) r_issued_all <= 1'b1;
          else                 r_cur        <= r_cur + 1'b1;
        end else begin
          r_dv <= 1'b0;
        end
      end else if (w_hold_go) begin
        // The held sample is consumed; the next code is already on chk_code_o.
        r_dv <= 1'b0;
      end
`else
      if (w_adv || w_hold_go) r_cur <= r_cur + 1'b1;
`endif

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_last <= last_code_i;
            r_cur  <= first_code_i;
            r_base <= first_code_i;
            r_pack <= '0;
            r_cnt  <= '0;
`ifdef PRM_SCAN_CHK_PIPE_EN
            r_dv         <= 1'b0;
            r_issued_all <= 1'b0;
`endif
            if (first_code_i > last_code_i) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (w_cmpl) begin
            if (w_out_free) begin
              r_valid <= 1'b1;
              r_data  <= w_pack_nxt;
              r_wbase <= r_base;
              r_pack  <= '0;
              if (w_final) r_state <= S_DRAIN;
              else         r_base  <= w_scode + 1'b1;
            end else begin
              r_pack  <= w_pack_nxt;
              r_state <= S_HOLD;
            end
          end else if (w_samp_v) begin
            r_pack <= w_pack_nxt;
          end
        end
        S_HOLD: begin
          if (w_out_free) begin
            r_valid <= 1'b1;
            r_data  <= r_pack;
            r_wbase <= r_base;
            r_pack  <= '0;
            if (w_final) begin
              r_state <= S_DRAIN;
            end else begin
              r_base  <= w_scode + 1'b1;
              r_state <= S_SCAN;
            end
          end
        end
        S_DRAIN: begin
          if (r_valid && word_ready_i) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign chk_code_o    = r_cur;
  assign word_valid_o  = r_valid;
  assign word_data_o   = r_data;
  assign word_base_o   = r_wbase;
  assign blocked_cnt_o = r_cnt;
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = r_done;

endmodule

`default_nettype wire

// File: doc/prm_edge_scan.md
Name: prm_edge_scan

Overview:
- Sequencer that sits directly upstream of a prm_oblgc_chk* obstacle-logic checker and consumes its result.
- Sweeps a 15-bit edge code over an inclusive range and drives the code onto the checker's A..O inputs, one code per cycle.
- Samples the checker's edge_mask, packs the results into 32-bit mask words and streams them out over a valid/ready interface.
- Counts blocked edges (mask = 1) for the roadmap builder.

Parameters:
- CODE_W, 15, edge code width; bit 0 = A … bit 14 = O.
- WORD_W, 32, mask bits per output word.
- CNT_W, 16, blocked-edge counter width; saturates at all-ones.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  begin scan; sampled only in IDLE.
- first_code_i  in  CODE_W  first code of range; latched on start.
- last_code_i  in  CODE_W  last code of range, inclusive; latched on start.
- chk_code_o  out  CODE_W  code driven to checker A..O.
- chk_mask_i  in  1  checker edge_mask, combinational from chk_code_o.
- word_valid_o  out  1  output word valid.
- word_ready_i  in  1  consumer accepts the word.
- word_data_o  out  WORD_W  bit k = mask of code word_base_o+k.
- word_base_o  out  CODE_W  code mapped to bit 0 of the word.
- blocked_cnt_o  out  CNT_W  count of mask=1 samples this scan.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at scan completion.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; pack register and counters cleared. Reset mid-scan aborts immediately with no residual word.
- FSM states: IDLE, SCAN, HOLD, DRAIN, FIN.
- IDLE:
  - On start_i, latch first/last, set cur = first, set base = first, clear the pack register and blocked_cnt_o.
  - Go to SCAN; if first > last, go to FIN instead (no words emitted).
- SCAN:
  - chk_code_o = cur.
  - Each cycle, pack[cur - base] <= chk_mask_i, and blocked_cnt_o increments when the mask is 1 (saturating).
  - A word completes when 32 bits are filled or cur == last.
  - On completion: if the output register is free (!word_valid_o, or word_ready_i this cycle), transfer the pack to word_data_o and word_base_o and set word_valid_o; otherwise go to HOLD.
  - Unfilled upper bits of a partial word are 0.
  - Termination is by equality cur == last; cur never increments past last, so last = 0x7FFF never wraps.
  - After the final word transfers, go to DRAIN. Otherwise cur++, and base = cur+1 when a new word starts.
- HOLD: cur and the pack are frozen and no sampling occurs; transfer when the output register frees, then resume SCAN or go to DRAIN.
- DRAIN: wait for word_valid_o && word_ready_i, then go to FIN.
- FIN: pulse done_o for 1 cycle, go to IDLE.
- Stream rules:
  - word_data_o and word_base_o are stable while valid && !ready.
  - valid never drops without a handshake.
  - Back-to-back transfer is allowed (load on the same cycle as accept).
- start_i while busy is ignored. chk_code_o holds its last value in IDLE.
- Throughput: 1 code/cycle with no backpressure. The first word is valid on cycle start+33 for a full word.

Optional Feature:
- Macro PRM_SCAN_CHK_PIPE_EN.
- Defined:
  - chk_code_o is registered, and chk_mask_i is treated as a registered checker output, so each mask pairs with the code issued one cycle earlier.
  - A 1-deep valid/index delay stage tracks in-flight codes, and HOLD freezes both the issue and the delay stage.
  - Word completion, counting and termination use the delayed index.
  - Every latency grows by exactly 1 cycle; data content is identical.
- Undefined: combinational same-cycle sampling as described above.

Test Plan (bench models the checker as chk_mask_i = chk_code_o[0]; in PIPE mode the model is registered):
- first=0x0000, last=0x001F, ready=1 -> one word 0xAAAAAAAA, base 0x0000, blocked=16, done pulse once, busy low afterwards.
- first=0x0010, last=0x0014 -> one word 0x0000000A, base 0x0010, blocked=2.
- first=0, last=95, ready held low for 10 cycles after the first valid -> three words 0xAAAAAAAA with bases 0x00, 0x20, 0x40; data stable while stalled, no loss or duplication, blocked=48.
- first=last=0x7FFF -> one word 0x00000001, base 0x7FFF, no wrap, blocked=1; second start accepted normally afterwards.
- first=5, last=3 -> no word_valid, done pulse 1 cycle after start, blocked=0; start_i pulsed mid-scan of a normal run is ignored.
- rst_n asserted during SCAN of range 0..63 -> all outputs 0 asynchronously; after release, start 0..31 yields the correct single word.
